cii_text_scanout: RTL
=====================

// Module: cii_text_scanout
// PURPOSE
//  Read side of the 70x30 character table. Walks the visible 640x480 raster in
//  9x16-pixel cells, reads each cell's ASCII code from the table RAM read port,
//  looks the glyph row up in the font ROM, and emits one RGB pixel per input
//  pixel strobe. It also overlays a blinking cursor at the current write position.
//  It sits between the VGA timing generator and the table RAM / font ROM.
// PARAMETERS
//  COLS         70        text columns; pixels 630..639 of each line are blank
//  ROWS         30        text rows
//  BLINK_FRAMES 30        frames per cursor phase; must be >= 1
//  FG_COLOR     24'hFFFFFF glyph colour
//  BG_COLOR     24'h000000 background colour
// PORTS
//  clk          in   1   system clock
//  rstn         in   1   asynchronous active-low reset
//  frame_start  in   1   1-cycle pulse before the first visible line of a frame
//  line_end     in   1   1-cycle pulse after the last visible pixel of each line
//  pix_vld      in   1   one visible pixel per asserted cycle, left to right
//  cur_x        in   7   cursor column (current write pointer x)
//  cur_y        in   5   cursor row (current write pointer y)
//  char_x_rd    out  7   table read column
//  char_y_rd    out  5   table read row
//  rd_vld       out  1   table read strobe
//  ascii_i      in   8   table data; valid the cycle after rd_vld
//  font_addr    out  12  {ascii[7:0], glyph_row[3:0]}
//  font_data    in   12  glyph row; valid the cycle after font_addr is presented;
//                        bit 0 = leftmost pixel, bits 11:9 ignored
//  vga_data     out  24  RGB pixel
//  vga_data_vld out  1   vga_data valid
// BEHAVIOUR
//  Reset (rstn=0, async): all counters 0; blink phase 0; all outputs 0.
//  Position counters: px 0..8, col 0..COLS, py 0..15, row 0..ROWS.
//  - pix_vld: px+1; at px==8, px->0 and col+1. col saturates at COLS (blank zone).
//  - line_end: px, col -> 0; py+1; at py==15, py->0 and row+1. row saturates at ROWS.
//  - frame_start: px, col, py, row -> 0; blink counter +1. When it reaches
//    BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
//  - frame_start takes priority over line_end and pix_vld in the same cycle.
//    line_end takes priority over pix_vld.
//  Pipeline (pixel sampled at cycle T; fixed latency 5, no stalls, one pixel per cycle):
//  - T+1: rd_vld=1; char_x_rd=col, char_y_rd=row (values at T). If col==COLS or
//    row==ROWS, rd_vld=0 and the pixel is marked blank.
//  - T+2: ascii_i sampled.
//  - T+3: font_addr={ascii,py}.
//  - T+4: font_data sampled.
//  - T+5: vga_data_vld=1; vga_data=FG_COLOR if glyph bit[px] is 1, else BG_COLOR.
//  - px, py and the cursor-hit flag travel down the pipeline with the pixel.
//  - Blank pixels, and pixels whose ascii==8'h00, force the glyph bit to 0.
//  - Cursor hit: col==cur_x, row==cur_y, blink phase==1, cur_x<COLS and cur_y<ROWS.
//    A hit inverts the pixel colour (FG<->BG), including for blank/0x00 cells.
//  - When no pixel is in flight: rd_vld=0 and vga_data_vld=0; vga_data holds its
//    last value. font_addr holds its last value.
//  - Reset mid-frame flushes the pipeline: no vga_data_vld until a new pix_vld.
//  - cur_x/cur_y are sampled per pixel at T; mid-frame changes take effect immediately.
// TESTING
//  1. Table all 0x41, font 'A' row 0 = 12'h010. 9 pix_vld after frame_start
//     -> table reads (0,0); vga_data_vld at T+5; pixel 4 = FG_COLOR, the others BG_COLOR.
//  2. 640 pix_vld in one line -> 630 rd_vld pulses, col 0..69.
//     Pixels 630..639 = BG_COLOR; 640 vga_data_vld pulses.
//  3. 16 lines with line_end -> char_y_rd steps 0->1 on line 16; font_addr
//     low nibble cycles 0..15. Line 481 (row==30): rd_vld stays 0 and the output is BG.
//  4. BLINK_FRAMES=2, cur=(3,0), table 0x00 -> cell 3 is all FG in frames where the
//     phase is 1 and all BG otherwise; the phase toggles every 2 frame_start pulses.
//  5. rstn low for 1 cycle while 3 pixels are in flight -> all outputs 0 at once;
//     no vga_data_vld afterwards; next frame_start plus pixel -> normal 5-cycle latency.
//  6. frame_start and line_end in the same cycle -> counters all 0;
//     py is not incremented.

Source files
------------

// File: rtl/cii_text_scanout.sv
// cii_text_scanout: read side of the text character table. Walks the visible
// raster in 9x16 cells, fetches ASCII codes and glyph rows, and emits one RGB
// pixel per pixel strobe with a fixed 5-cycle latency and a blinking cursor.
module cii_text_scanout #(
  parameter int          COLS         = 70,
  parameter int          ROWS         = 30,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR     = 24'h000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        frame_start,
  input  logic        line_end,
  input  logic        pix_vld,
  input  logic [6:0]  cur_x,
  input  logic [4:0]  cur_y,
  output logic [6:0]  char_x_rd,
  output logic [4:0]  char_y_rd,
  output logic        rd_vld,
  input  logic [7:0]  ascii_i,
  output logic [11:0] font_addr,
  input  logic [11:0] font_data,
  output logic [23:0] vga_data,
  output logic        vga_data_vld
);

  localparam int             BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0]     COL_END    = 7'(COLS);
  localparam logic [4:0]     ROW_END    = 5'(ROWS);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // raster position and blink state
  logic [3:0]    px, py;
  logic [6:0]    col;
  logic [4:0]    row;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  // per-stage pixel attributes
  logic       v1, v2, v3, v4;
  logic [3:0] px1, px2, px3, px4;
  logic [3:0] py1, py2;
  logic       blank1, blank2;
  logic       zero3, zero4;
  logic       hit1, hit2, hit3, hit4;

  logic launch, blank0, hit0;

  // a pixel strobe coinciding with frame_start or line_end is dropped
  always_comb begin
    launch = pix_vld & ~frame_start & ~line_end;
    blank0 = (col == COL_END) || (row == ROW_END);
    hit0   = (col == cur_x) && (row == cur_y) && blink_ph &&
             (cur_x < COL_END) && (cur_y < ROW_END);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      px        <= '0;
      col       <= '0;
      py        <= '0;
      row       <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (frame_start) begin
      px  <= '0;
      col <= '0;
      py  <= '0;
      row <= '0;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else if (line_end) begin
      px  <= '0;
      col <= '0;
      if (py == 4'd15) begin
        py <= '0;
        if (row != ROW_END) row <= row + 1'b1;
      end else begin
        py <= py + 1'b1;
      end
    end else if (pix_vld) begin
      if (px == 4'd8) begin
        px <= '0;
        if (col != COL_END) col <= col + 1'b1;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

  // five-stage fetch pipeline: table read, ascii wait, font addr, font wait, pixel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      px1 <= '0; px2 <= '0; px3 <= '0; px4 <= '0;
      py1 <= '0; py2 <= '0;
      blank1 <= 1'b0; blank2 <= 1'b0;
      zero3 <= 1'b0; zero4 <= 1'b0;
      hit1 <= 1'b0; hit2 <= 1'b0; hit3 <= 1'b0; hit4 <= 1'b0;
      rd_vld       <= 1'b0;
      char_x_rd    <= '0;
      char_y_rd    <= '0;
      font_addr    <= '0;
      vga_data     <= '0;
      vga_data_vld <= 1'b0;
    end else begin
      v1     <= launch;
      rd_vld <= launch & ~blank0;
      if (launch) begin
        char_x_rd <= col;
        char_y_rd <= row;
        px1       <= px;
        py1       <= py;
        blank1    <= blank0;
        hit1      <= hit0;
      end

      v2 <= v1;
      if (v1) begin
        px2    <= px1;
        py2    <= py1;
        blank2 <= blank1;
        hit2   <= hit1;
      end

      v3 <= v2;
      if (v2) begin
        font_addr <= {ascii_i, py2};
        zero3     <= blank2 | (ascii_i == 8'h00);
        px3       <= px2;
        hit3      <= hit2;
      end

      v4 <= v3;
      if (v3) begin
        zero4 <= zero3;
        px4   <= px3;
        hit4  <= hit3;
      end

      vga_data_vld <= v4;
      if (v4) begin
        vga_data <= ((~zero4 & font_data[px4]) ^ hit4) ? FG_COLOR : BG_COLOR;
      end
    end
  end

endmodule
